// File: rtl/fsm_embalagem_if.sv
// rtl/fsm_embalagem_if.sv - packaging stage signal bundle (line side = master, packaging FSM = slave)
interface fsm_embalagem_if;
    logic       GARRAFA_APROVADA;
    logic       CAIXA_PRESENTE;
    logic       PEDIR_CAIXA;
    logic       BRACO_ATIVO;
    logic       FECHADOR_ATIVO;
    logic       CAIXA_CHEIA;
    logic       CAIXA_FECHADA;
    logic       PARAR_LINHA;
    logic       ALARME_TRANSBORDO;
    logic       ALARME_CAIXA;
    logic [3:0] GARRAFAS_NA_CAIXA;
    logic [2:0] BUFFER_COUNT;
    logic [7:0] CAIXAS_FECHADAS;

    modport master (
        output GARRAFA_APROVADA, CAIXA_PRESENTE,
        input  PEDIR_CAIXA, BRACO_ATIVO, FECHADOR_ATIVO, CAIXA_CHEIA, CAIXA_FECHADA,
               PARAR_LINHA, ALARME_TRANSBORDO, ALARME_CAIXA,
               GARRAFAS_NA_CAIXA, BUFFER_COUNT, CAIXAS_FECHADAS
    );

    modport slave (
        input  GARRAFA_APROVADA, CAIXA_PRESENTE,
        output PEDIR_CAIXA, BRACO_ATIVO, FECHADOR_ATIVO, CAIXA_CHEIA, CAIXA_FECHADA,
               PARAR_LINHA, ALARME_TRANSBORDO, ALARME_CAIXA,
               GARRAFAS_NA_CAIXA, BUFFER_COUNT, CAIXAS_FECHADAS
    );
endinterface

// File: rtl/fsm_embalagem.sv
// rtl/fsm_embalagem.sv - packaging FSM: bottle buffer, timed transfer arm, box closer, box handling
module fsm_embalagem #(
    parameter int GARRAFAS_POR_CAIXA = 12,
    parameter int BUF_DEPTH          = 4,
    parameter int T_TRANSF           = 3,
    parameter int T_FECHA            = 5
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    fsm_embalagem_if.slave bus
);
    typedef enum logic [2:0] {
        SEM_CAIXA,
        OCIOSO,
        TRANSFERINDO,
        FECHANDO,
        CAIXA_PRONTA
    } estado_t;

    localparam logic [3:0]  GPC   = 4'(GARRAFAS_POR_CAIXA);
    localparam logic [2:0]  BD    = 3'(BUF_DEPTH);
    localparam logic [15:0] T_TR  = 16'(T_TRANSF - 1);
    localparam logic [15:0] T_FE  = 16'(T_FECHA - 1);

    estado_t     estado;
    logic [15:0] timer;
    logic [2:0]  buffer_count;
    logic [3:0]  garrafas;
    logic [7:0]  caixas;
    logic        alarme_transbordo;
    logic        alarme_caixa;
    logic        caixa_fechada;

    logic push, pop, buffer_cheio, presente;

    assign presente     = bus.CAIXA_PRESENTE;
    assign push         = bus.GARRAFA_APROVADA;
    assign buffer_cheio = (buffer_count == BD);
    // A pop happens exactly on the OCIOSO -> TRANSFERINDO transition
    assign pop          = (estado == OCIOSO) && presente && (buffer_count != 3'd0);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado            <= SEM_CAIXA;
            timer             <= '0;
            buffer_count      <= '0;
            garrafas          <= '0;
            caixas            <= '0;
            alarme_transbordo <= 1'b0;
            alarme_caixa      <= 1'b0;
            caixa_fechada     <= 1'b0;
        end else begin
            caixa_fechada <= 1'b0;

            if (push && !pop) begin
                if (!buffer_cheio)
                    buffer_count <= buffer_count + 3'd1;
                else
                    alarme_transbordo <= 1'b1;
            end else if (pop && !push) begin
                buffer_count <= buffer_count - 3'd1;
            end

            case (estado)
                SEM_CAIXA: begin
                    garrafas <= '0;
                    if (presente)
                        estado <= OCIOSO;
                end
                OCIOSO: begin
                    if (!presente) begin
                        estado       <= SEM_CAIXA;
                        alarme_caixa <= 1'b1;
                    end else if (buffer_count != 3'd0) begin
                        estado <= TRANSFERINDO;
                        timer  <= T_TR;
                    end
                end
                TRANSFERINDO: begin
                    // Box pulled mid-transfer: the bottle on the arm is lost
                    if (!presente) begin
                        estado       <= SEM_CAIXA;
                        alarme_caixa <= 1'b1;
                        garrafas     <= '0;
                    end else if (timer != 16'd0) begin
                        timer <= timer - 16'd1;
                    end else begin
                        garrafas <= garrafas + 4'd1;
                        if (garrafas + 4'd1 == GPC) begin
                            estado <= FECHANDO;
                            timer  <= T_FE;
                        end else begin
                            estado <= OCIOSO;
                        end
                    end
                end
                FECHANDO: begin
                    if (!presente) begin
                        estado       <= SEM_CAIXA;
                        alarme_caixa <= 1'b1;
                        garrafas     <= '0;
                    end else if (timer != 16'd0) begin
                        timer <= timer - 16'd1;
                    end else begin
                        estado        <= CAIXA_PRONTA;
                        caixa_fechada <= 1'b1;
                        if (caixas != 8'hFF)
                            caixas <= caixas + 8'd1;
                    end
                end
                CAIXA_PRONTA: begin
                    if (!presente) begin
                        estado   <= SEM_CAIXA;
                        garrafas <= '0;
                    end
                end
                default: estado <= SEM_CAIXA;
            endcase
        end
    end

    assign bus.PEDIR_CAIXA       = (estado == SEM_CAIXA);
    assign bus.BRACO_ATIVO       = (estado == TRANSFERINDO);
    assign bus.FECHADOR_ATIVO    = (estado == FECHANDO);
    assign bus.CAIXA_CHEIA       = (estado == CAIXA_PRONTA);
    assign bus.CAIXA_FECHADA     = caixa_fechada;
    assign bus.PARAR_LINHA       = buffer_cheio;
    assign bus.ALARME_TRANSBORDO = alarme_transbordo;
    assign bus.ALARME_CAIXA      = alarme_caixa;
    assign bus.GARRAFAS_NA_CAIXA = garrafas;
    assign bus.BUFFER_COUNT      = buffer_count;
    assign bus.CAIXAS_FECHADAS   = caixas;
endmodule

// File: tb/tb_fsm_embalagem.sv
// tb/tb_fsm_embalagem.sv - directed bench for the packaging FSM
module tb_fsm_embalagem;
    logic CLOCK;
    logic RESET_N;
    int   nchecks;
    int   nerr;

    fsm_embalagem_if bus();

    fsm_embalagem dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pedir"},      32'(bus.PEDIR_CAIXA), 1);
        chk({tag, "_braco"},      32'(bus.BRACO_ATIVO), 0);
        chk({tag, "_fechador"},   32'(bus.FECHADOR_ATIVO), 0);
        chk({tag, "_cheia"},      32'(bus.CAIXA_CHEIA), 0);
        chk({tag, "_fechada"},    32'(bus.CAIXA_FECHADA), 0);
        chk({tag, "_parar"},      32'(bus.PARAR_LINHA), 0);
        chk({tag, "_transbordo"}, 32'(bus.ALARME_TRANSBORDO), 0);
        chk({tag, "_al_caixa"},   32'(bus.ALARME_CAIXA), 0);
        chk({tag, "_garrafas"},   32'(bus.GARRAFAS_NA_CAIXA), 0);
        chk({tag, "_buffer"},     32'(bus.BUFFER_COUNT), 0);
        chk({tag, "_caixas"},     32'(bus.CAIXAS_FECHADAS), 0);
    endtask

    initial begin
        int fech_cnt;
        int pulse_cnt;
        int pulse_at;
        bit found;

        nchecks = 0;
        nerr    = 0;
        RESET_N = 1'b0;
        bus.GARRAFA_APROVADA = 1'b0;
        bus.CAIXA_PRESENTE   = 1'b0;
        repeat (2) @(negedge CLOCK);
        chk_reset_values("rst");
        RESET_N = 1'b1;
        @(negedge CLOCK);

        // 1: box arrives
        bus.CAIXA_PRESENTE = 1'b1;
        @(negedge CLOCK);
        chk("t1_pedir_low", 32'(bus.PEDIR_CAIXA), 0);

        // 2: single bottle latency
        bus.GARRAFA_APROVADA = 1'b1;
        @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t2_buf_n1",   32'(bus.BUFFER_COUNT), 1);
        chk("t2_braco_n1", 32'(bus.BRACO_ATIVO), 0);
        @(negedge CLOCK);
        chk("t2_braco_n2", 32'(bus.BRACO_ATIVO), 1);
        chk("t2_buf_n2",   32'(bus.BUFFER_COUNT), 0);
        @(negedge CLOCK);
        chk("t2_braco_n3", 32'(bus.BRACO_ATIVO), 1);
        @(negedge CLOCK);
        chk("t2_braco_n4", 32'(bus.BRACO_ATIVO), 1);
        chk("t2_garr_n4",  32'(bus.GARRAFAS_NA_CAIXA), 0);
        @(negedge CLOCK);
        chk("t2_braco_n5", 32'(bus.BRACO_ATIVO), 0);
        chk("t2_garr_n5",  32'(bus.GARRAFAS_NA_CAIXA), 1);

        // 3: fill the box, 10 cycles between bottles
        for (int b = 0; b < 10; b++) begin
            bus.GARRAFA_APROVADA = 1'b1;
            @(negedge CLOCK);
            bus.GARRAFA_APROVADA = 1'b0;
            repeat (9) @(negedge CLOCK);
        end
        chk("t3_garr_11", 32'(bus.GARRAFAS_NA_CAIXA), 11);
        fech_cnt  = 0;
        pulse_cnt = 0;
        pulse_at  = 0;
        bus.GARRAFA_APROVADA = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLOCK);
            bus.GARRAFA_APROVADA = 1'b0;
            if (bus.FECHADOR_ATIVO) fech_cnt++;
            if (bus.CAIXA_FECHADA) begin
                pulse_cnt++;
                pulse_at = i;
            end
        end
        chk("t3_fechador_cycles", 32'(fech_cnt), 5);
        chk("t3_fechada_pulses",  32'(pulse_cnt), 1);
        chk("t3_fechada_cycle",   32'(pulse_at), 10);
        chk("t3_caixas",          32'(bus.CAIXAS_FECHADAS), 1);
        chk("t3_cheia",           32'(bus.CAIXA_CHEIA), 1);
        chk("t3_garr_12",         32'(bus.GARRAFAS_NA_CAIXA), 12);
        bus.CAIXA_PRESENTE = 1'b0;
        @(negedge CLOCK);
        chk("t3_pedir",    32'(bus.PEDIR_CAIXA), 1);
        chk("t3_garr_clr", 32'(bus.GARRAFAS_NA_CAIXA), 0);
        chk("t3_no_alarm", 32'(bus.ALARME_CAIXA), 0);

        // 4: overflow with no box, then drain
        bus.GARRAFA_APROVADA = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("t4_parar_3", 32'(bus.PARAR_LINHA), 0);
        @(negedge CLOCK);
        chk("t4_buf_4",   32'(bus.BUFFER_COUNT), 4);
        chk("t4_parar_4", 32'(bus.PARAR_LINHA), 1);
        chk("t4_trans_4", 32'(bus.ALARME_TRANSBORDO), 0);
        @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t4_buf_5",   32'(bus.BUFFER_COUNT), 4);
        chk("t4_trans_5", 32'(bus.ALARME_TRANSBORDO), 1);
        bus.CAIXA_PRESENTE = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLOCK);
            if (bus.GARRAFAS_NA_CAIXA == 4'd4) found = 1'b1;
        end
        chk("t4_drain_seen", 32'(found), 1);
        chk("t4_buf_empty",  32'(bus.BUFFER_COUNT), 0);
        chk("t4_parar_off",  32'(bus.PARAR_LINHA), 0);

        // 5: box pulled mid-transfer
        RESET_N = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        for (int b = 0; b < 3; b++) begin
            bus.GARRAFA_APROVADA = 1'b1;
            @(negedge CLOCK);
            bus.GARRAFA_APROVADA = 1'b0;
            repeat (9) @(negedge CLOCK);
        end
        chk("t5_garr_3", 32'(bus.GARRAFAS_NA_CAIXA), 3);
        bus.GARRAFA_APROVADA = 1'b1;
        repeat (3) @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t5_braco_pre", 32'(bus.BRACO_ATIVO), 1);
        chk("t5_buf_pre",   32'(bus.BUFFER_COUNT), 2);
        bus.CAIXA_PRESENTE = 1'b0;
        @(negedge CLOCK);
        chk("t5_alarm",  32'(bus.ALARME_CAIXA), 1);
        chk("t5_garr",   32'(bus.GARRAFAS_NA_CAIXA), 0);
        chk("t5_buf",    32'(bus.BUFFER_COUNT), 2);
        chk("t5_pedir",  32'(bus.PEDIR_CAIXA), 1);
        chk("t5_caixas", 32'(bus.CAIXAS_FECHADAS), 0);

        // 6: push coincident with pop at full buffer, then async reset mid-closing
        bus.GARRAFA_APROVADA = 1'b1;
        repeat (2) @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t6_full", 32'(bus.PARAR_LINHA), 1);
        bus.CAIXA_PRESENTE = 1'b1;
        @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b1;
        @(negedge CLOCK);
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t6_buf_same",  32'(bus.BUFFER_COUNT), 4);
        chk("t6_no_trans",  32'(bus.ALARME_TRANSBORDO), 0);
        chk("t6_braco",     32'(bus.BRACO_ATIVO), 1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            bus.GARRAFA_APROVADA = (bus.BUFFER_COUNT < 3'd2);
            @(negedge CLOCK);
            if (bus.FECHADOR_ATIVO) found = 1'b1;
        end
        bus.GARRAFA_APROVADA = 1'b0;
        chk("t6_fechando_seen", 32'(found), 1);
        @(negedge CLOCK);
        chk("t6_fechando_still", 32'(bus.FECHADOR_ATIVO), 1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_reset_values("t6_async");
        @(negedge CLOCK);
        RESET_N = 1'b1;

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
